rc4_key_dispatcher: RTL and testbench
=====================================

# rc4_key_dispatcher

Multi-channel key-space dispatcher for the RC4 brute-force cracker. It walks a configurable key range [KEY_LOWER, KEY_UPPER] and hands out one key per request to NUM_CH independent decryption cores, using round-robin arbitration. The block sits between the top-level control FSM and the per-core `decrypt_core` instances. It replaces the single-core key stepper with request/grant dispatch, an early stop on a key hit, range exhaustion reporting and restart.

## Interface
- KEY_BYTES, 3, number of key bytes
- BYTE_WIDTH, 8, bits per key byte; KW = KEY_BYTES*BYTE_WIDTH
- NUM_CH, 4, number of consumer channels (1..16)
- KEY_LOWER, 0, first key issued (KW bits)
- KEY_UPPER, 2^KW-1, last key issued, inclusive; KEY_UPPER >= KEY_LOWER
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  level; a rising edge starts or restarts a sweep
- stop  in  1  level; key found, halt dispatch
- req  in  NUM_CH  per-channel single-cycle key request pulse
- key_out  out  NUM_CH x [KEY_BYTES-1:0][BYTE_WIDTH-1:0]  per-channel key, held until that channel's next grant
- key_valid  out  NUM_CH  one-cycle pulse marking a new key_out[i]
- busy  out  1  state == RUNNING
- exhausted  out  1  state == EXHAUSTED
- halted  out  1  state == HALTED

## Operation
- States: IDLE, RUNNING, EXHAUSTED, HALTED.
- start_pulse = start & ~start_q, where start_q is a one-register delay of start.
- Transitions, in priority order:
  - IDLE: start_pulse -> RUNNING.
  - RUNNING: stop -> HALTED; else cursor > KEY_UPPER -> EXHAUSTED.
  - EXHAUSTED / HALTED: start_pulse -> RUNNING, cursor <= KEY_LOWER, pending <= 0, rr_ptr <= 0.
  - RUNNING ignores start_pulse.
- cursor is KW+1 bits wide, so the increment past the all-ones key does not wrap. It is loaded with KEY_LOWER on reset and on every start_pulse.
- pending[i] is set by req[i] only while RUNNING and is cleared on grant. A req[i] while pending[i] is already set is absorbed. A req outside RUNNING is dropped.
- Grant: while RUNNING, with no stop and cursor <= KEY_UPPER, at most one grant per cycle.
  - The grant goes to the first pending channel at or after rr_ptr, modulo NUM_CH.
  - On grant to channel g: key_out[g] <= cursor[KW-1:0], key_valid[g] <= 1, cursor <= cursor+1, rr_ptr <= (g+1) mod NUM_CH.
- A req[i] arriving in the same cycle as a grant to i sets pending again, because set has priority over clear.
- stop asserted in the same cycle as a would-be grant suppresses that grant. No key is lost: cursor does not advance.
- After KEY_UPPER is issued, the cycle with cursor = KEY_UPPER+1 moves the state to EXHAUSTED. Pending requests stay unanswered and are cleared on restart.
- Reset values: key_out all 0, key_valid 0, busy 0, exhausted 0, halted 0, state IDLE, cursor KEY_LOWER, rr_ptr 0, pending 0, start_q 0.
- Reset mid-sweep aborts immediately. No key_valid is emitted in the cycle after reset.

## Timing
- Start: if start is low at edge N-1 and high at edge N, busy is high after edge N.
- Request latency: req[i] pulse sampled at edge N sets pending. The grant is evaluated at edge N+1, so key_valid[i] and key_out[i] are valid in the cycle after edge N+1, i.e. 2 cycles after the request. Under contention, each extra cycle waited per higher-priority pending channel adds one cycle.
- Throughput: one key per cycle aggregate.
- stop sampled at edge N: halted is high after N, and no key_valid appears in the cycle after N.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- RC4_KEY_DISPATCH_PROGRESS_EN defined: adds output `issued_count` (KW+1 bits).
  - Cleared on reset and on start_pulse.
  - Incremented on each grant.
  - Holds its value in EXHAUSTED and HALTED.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `rc4_keygen_pkg`: holds the `dispatch_state_t` enum and a `key_t` typedef parameterised via localparams.
- Sub-module `rr_arbiter`: parameter N; inputs pending and ptr; outputs one-hot grant and a grant_valid flag. It is combinational and reused by the core-select logic.
- The existing `edge_detector` is not used. The single start_q register is kept inline so the start latency matches the Timing section exactly.

## Test plan
Parameters for all scenarios: KEY_LOWER=0x000010, KEY_UPPER=0x000015, NUM_CH=4.
- Reset, then start edge, then req[0] pulse -> key_valid[0] 2 cycles later with key_out[0]=0x000010; cursor advances to 0x11.
- req[0..3] pulsed in the same cycle -> grants on consecutive cycles to ch0, 1, 2, 3 with keys 0x10, 0x11, 0x12, 0x13.
- Continue requesting until 6 keys issued -> the last key is 0x15, exhausted=1 one cycle later, and a further req gives no key_valid.
- stop raised in the cycle a grant to ch2 is due -> no key_valid[2], halted=1, cursor unchanged.
- Start edge in HALTED -> busy=1 and the next grant issues 0x10. A start edge while RUNNING has no effect.
- KEY_LOWER=KEY_UPPER=0xFFFFFF -> exactly one key 0xFFFFFF, then EXHAUSTED with no wrap to 0; with PROGRESS_EN, issued_count=1.

Source files
------------

// File: rtl/rc4_keygen_pkg.sv
// ============================================================================
// rc4_keygen_pkg : shared types and helpers for the RC4 key dispatcher.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package rc4_keygen_pkg;

  localparam int KEY_BYTES_P  = 3;
  localparam int BYTE_WIDTH_P = 8;

  typedef logic [KEY_BYTES_P-1:0][BYTE_WIDTH_P-1:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_EXHAUSTED = 2'd2,
    ST_HALTED    = 2'd3
  } dispatch_state_t;

  // Pointer width for an N-entry ring; never zero so N=1 still elaborates.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rc4_key_dispatcher_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin picker, first pending at/after ptr.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import rc4_keygen_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              pending,
  input  logic [ptr_width(N)-1:0]   ptr,
  output logic [N-1:0]              grant,
  output logic                      grant_valid
);

  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_first;
  logic           w_found;
  logic [2*N-1:0] w_gdbl;

  // Rotate so that ptr lands at bit 0, pick lowest set bit, rotate back.
  assign w_rot = N'({pending, pending} >> ptr);

  always_comb begin
    w_first = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_rot[k] && !w_found) begin
        w_first[k] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign w_gdbl      = {{N{1'b0}}, w_first} << ptr;
  assign grant       = w_gdbl[2*N-1:N] | w_gdbl[N-1:0];
  assign grant_valid = |pending;

endmodule

`default_nettype wire

// File: rtl/rc4_key_dispatcher.sv
// ============================================================================
// rc4_key_dispatcher : round-robin key-range dispatcher for NUM_CH RC4 cores.
// Optional RC4_KEY_DISPATCH_PROGRESS_EN adds the issued_count output.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_key_dispatcher
  import rc4_keygen_pkg::*;
#(
  parameter int KEY_BYTES  = 3,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter logic [KEY_BYTES*BYTE_WIDTH-1:0] KEY_LOWER = '0,
  parameter logic [KEY_BYTES*BYTE_WIDTH-1:0] KEY_UPPER = '1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic                                           stop,
  input  logic [NUM_CH-1:0]                              req,
  output logic [NUM_CH-1:0][KEY_BYTES-1:0][BYTE_WIDTH-1:0] key_out,
  output logic [NUM_CH-1:0]                              key_valid,
  output logic                                           busy,
  output logic                                           exhausted,
  output logic                                           halted
`ifdef RC4_KEY_DISPATCH_PROGRESS_EN
  ,
  output logic [KEY_BYTES*BYTE_WIDTH:0]                  issued_count
`endif
);

  localparam int KW = KEY_BYTES * BYTE_WIDTH;
  localparam int PW = ptr_width(NUM_CH);

  dispatch_state_t r_state;
  dispatch_state_t w_state_next;
  logic            r_start_q;
  logic [KW:0]     r_cursor;
  logic [NUM_CH-1:0] r_pending;
  logic [PW-1:0]   r_rr_ptr;

  logic              w_start_pulse;
  logic              w_in_range;
  logic              w_running;
  logic              w_restart;
  logic [NUM_CH-1:0] w_grant;
  logic              w_grant_valid;
  logic              w_grant_en;
  logic [NUM_CH-1:0] w_grant_mask;
  logic [PW-1:0]     w_next_ptr;

  assign w_start_pulse = start & ~r_start_q;
  assign w_running     = (r_state == ST_RUNNING);
  // cursor carries one extra bit so stepping past the all-ones key cannot wrap.
  assign w_in_range    = (r_cursor <= {1'b0, KEY_UPPER});
  assign w_restart     = w_start_pulse && !w_running;
  assign w_grant_en    = w_running && !stop && w_in_range && w_grant_valid;
  assign w_grant_mask  = w_grant_en ? w_grant : '0;

  rr_arbiter #(
    .N(NUM_CH)
  ) u_arb (
    .pending    (r_pending),
    .ptr        (r_rr_ptr),
    .grant      (w_grant),
    .grant_valid(w_grant_valid)
  );

  always_comb begin
    w_next_ptr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_next_ptr = (i == NUM_CH-1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_start_pulse) w_state_next = ST_RUNNING;
      ST_RUNNING: begin
        if (stop)             w_state_next = ST_HALTED;
        else if (!w_in_range) w_state_next = ST_EXHAUSTED;
      end
      ST_EXHAUSTED,
      ST_HALTED:    if (w_start_pulse) w_state_next = ST_RUNNING;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
      r_cursor  <= {1'b0, KEY_LOWER};
      r_pending <= '0;
      r_rr_ptr  <= '0;
      key_out   <= '0;
      key_valid <= '0;
      busy      <= 1'b0;
      exhausted <= 1'b0;
      halted    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= start;
      key_valid <= w_grant_mask;
      busy      <= (w_state_next == ST_RUNNING);
      exhausted <= (w_state_next == ST_EXHAUSTED);
      halted    <= (w_state_next == ST_HALTED);
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_grant_mask[i]) key_out[i] <= r_cursor[KW-1:0];
      end
      if (w_restart) begin
        r_cursor  <= {1'b0, KEY_LOWER};
        r_pending <= '0;
        r_rr_ptr  <= '0;
      end else begin
        if (w_grant_en) begin
          r_cursor <= r_cursor + {{KW{1'b0}}, 1'b1};
          r_rr_ptr <= w_next_ptr;
        end
        // A fresh request wins over the clear from a same-cycle grant.
        r_pending <= (r_pending & ~w_grant_mask) | (w_running ? req : '0);
      end
    end
  end

`ifdef RC4_KEY_DISPATCH_PROGRESS_EN
  always_ff @(posedge clk) begin
    if (reset || w_restart) begin
      issued_count <= '0;
    end else if (w_grant_en) begin
      issued_count <= issued_count + {{KW{1'b0}}, 1'b1};
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rc4_key_dispatcher.sv
// ============================================================================
// tb_rc4_key_dispatcher : scoreboard bench with a transaction-level key model.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rc4_key_dispatcher;

  localparam int NCH = 4;
  localparam int KW  = 24;
  localparam int LOW = 'h10;
  localparam int UP  = 'h15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst1 = 1'b1, start1 = 1'b0, stop1 = 1'b0;
  logic [NCH-1:0]       req1 = '0;
  logic [NCH-1:0][2:0][7:0] kout1;
  logic [NCH-1:0]       kv1;
  logic                 busy1, exh1, halt1;
  logic                 rst2 = 1'b1, start2 = 1'b0, stop2 = 1'b0;
  logic [NCH-1:0]       req2 = '0;
  logic [NCH-1:0][2:0][7:0] kout2;
  logic [NCH-1:0]       kv2;
  logic                 busy2, exh2, halt2;
`ifdef RC4_KEY_DISPATCH_PROGRESS_EN
  logic [KW:0]          cnt1, cnt2;
`endif

  rc4_key_dispatcher #(.KEY_BYTES(3), .BYTE_WIDTH(8), .NUM_CH(NCH),
                       .KEY_LOWER(24'h000010), .KEY_UPPER(24'h000015)) u_dut (
    .clk(clk), .reset(rst1), .start(start1), .stop(stop1), .req(req1),
    .key_out(kout1), .key_valid(kv1), .busy(busy1), .exhausted(exh1), .halted(halt1)
`ifdef RC4_KEY_DISPATCH_PROGRESS_EN
    , .issued_count(cnt1)
`endif
  );

  rc4_key_dispatcher #(.KEY_BYTES(3), .BYTE_WIDTH(8), .NUM_CH(NCH),
                       .KEY_LOWER(24'hFFFFFF), .KEY_UPPER(24'hFFFFFF)) u_dut2 (
    .clk(clk), .reset(rst2), .start(start2), .stop(stop2), .req(req2),
    .key_out(kout2), .key_valid(kv2), .busy(busy2), .exhausted(exh2), .halted(halt2)
`ifdef RC4_KEY_DISPATCH_PROGRESS_EN
    , .issued_count(cnt2)
`endif
  );

  typedef struct { int tag; int ch; int key; } key_exp_t;
  typedef struct { int tag; int st; int cnt; } st_exp_t;

  key_exp_t keyq[$];
  st_exp_t  stq[$];
  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Reference model: 0 idle, 1 running, 2 exhausted, 3 halted.
  int m_state = 0, m_cur = LOW, m_ptr = 0, m_cnt = 0;
  bit m_sq = 0;
  bit m_pend [NCH];

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Apply one cycle of inputs to u_dut and record what the next edge must produce.
  task automatic step(input bit r, input bit s, input bit st, input logic [NCH-1:0] rq);
    int e, old_cur, ns;
    bit sp, found;
    key_exp_t k;
    st_exp_t  x;
    rst1 = r; start1 = s; stop1 = st; req1 = rq;
    e = edge_cnt + 1;
    if (r) begin
      m_state = 0; m_cur = LOW; m_ptr = 0; m_cnt = 0; m_sq = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      sp = s && !m_sq;
      m_sq = s;
      old_cur = m_cur;
      ns = m_state;
      if (m_state == 1 && !st && m_cur <= UP) begin
        found = 0;
        for (int j = 0; j < NCH; j++) begin
          int g;
          g = (m_ptr + j) % NCH;
          if (!found && m_pend[g]) begin
            found = 1;
            k.tag = e; k.ch = g; k.key = m_cur;
            keyq.push_back(k);
            m_cur++; m_cnt++;
            m_ptr = (g + 1) % NCH;
            m_pend[g] = 0;
          end
        end
      end
      if (m_state == 1)
        for (int i = 0; i < NCH; i++) if (rq[i]) m_pend[i] = 1;
      case (m_state)
        0: if (sp) begin ns = 1; m_cnt = 0; m_cur = LOW; end
        1: if (st) ns = 3; else if (old_cur > UP) ns = 2;
        default: if (sp) begin
          ns = 1; m_cur = LOW; m_ptr = 0; m_cnt = 0;
          foreach (m_pend[i]) m_pend[i] = 0;
        end
      endcase
      m_state = ns;
    end
    x.tag = e; x.st = m_state; x.cnt = m_cnt;
    stq.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit s);
    for (int i = 0; i < n; i++) step(0, s, 0, '0);
  endtask

  // Monitor: compare u_dut outputs after every edge against queued expectations.
  initial begin
    st_exp_t  se;
    key_exp_t ke;
    int e;
    forever begin
      @(posedge clk);
      #1;
      e = edge_cnt;
      while (stq.size() > 0 && stq[0].tag < e) void'(stq.pop_front());
      if (stq.size() > 0 && stq[0].tag == e) begin
        se = stq.pop_front();
        chk("status", {29'd0, busy1, exh1, halt1},
            {29'd0, se.st == 1, se.st == 2, se.st == 3});
`ifdef RC4_KEY_DISPATCH_PROGRESS_EN
        chk("issued_count", 32'(cnt1), se.cnt);
`endif
        if (keyq.size() > 0 && keyq[0].tag == e) begin
          ke = keyq.pop_front();
          chk("key_valid", 32'(kv1), 32'(1) << ke.ch);
          chk("key_out", 32'(kout1[ke.ch]), ke.key);
        end else begin
          chk("key_valid_quiet", 32'(kv1), 0);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset, start, single request -> 0x10 two cycles later.
    step(1, 0, 0, '0); step(1, 0, 0, '0); step(1, 0, 0, '0);
    idle(2, 0);
    step(0, 1, 0, '0);
    step(0, 1, 0, 4'b0001); idle(3, 1);
    // All four at once -> consecutive grants 0x11..0x14.
    step(0, 1, 0, 4'b1111); idle(5, 1);
    // Last key 0x15, then exhaustion and a dropped request.
    step(0, 1, 0, 4'b0010); idle(3, 1);
    step(0, 1, 0, 4'b0001); idle(3, 1);
    // Restart from EXHAUSTED, then stop exactly when ch2's grant is due.
    step(0, 0, 0, '0); step(0, 1, 0, '0);
    step(0, 1, 0, 4'b1111); step(0, 1, 0, '0); step(0, 1, 0, '0);
    step(0, 1, 1, '0); step(0, 1, 1, '0); idle(2, 1);
    // Restart from HALTED, then a start edge while running is ignored.
    step(0, 0, 0, '0); step(0, 1, 0, '0);
    step(0, 1, 0, 4'b0100); step(0, 0, 0, '0);
    step(0, 1, 0, 4'b1000); idle(4, 1);
    // Randomized traffic.
    begin
      bit s = 1;
      for (int c = 0; c < 600; c++) begin
        bit r, st;
        logic [NCH-1:0] rq;
        r  = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 19) == 0) s = ~s;
        st = ($urandom_range(0, 29) == 0);
        rq = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
        step(r, s, st, rq);
      end
    end
    idle(4, 0);
    chk("scoreboard_drained", keyq.size(), 0);

    // Single-key range at the top of the key space.
    rst2 = 1; @(negedge clk); @(negedge clk); rst2 = 0; @(negedge clk);
    chk("d2_reset_status", {busy2, exh2, halt2}, 0);
    chk("d2_reset_kv", 32'(kv2), 0);
    start2 = 1; @(negedge clk);
    chk("d2_busy", 32'(busy2), 1);
    req2 = 4'b0010; @(negedge clk); req2 = '0;
    chk("d2_kv_early", 32'(kv2), 0);
    @(negedge clk);
    chk("d2_kv", 32'(kv2), 4'b0010);
    chk("d2_key", 32'(kout2[1]), 32'h00FFFFFF);
    @(negedge clk);
    chk("d2_exhausted", {busy2, exh2, halt2}, 3'b010);
    chk("d2_kv_after", 32'(kv2), 0);
    req2 = 4'b0001; @(negedge clk); req2 = '0;
    chk("d2_kv_dropped0", 32'(kv2), 0);
    @(negedge clk);
    chk("d2_kv_dropped1", 32'(kv2), 0);
    chk("d2_key_held", 32'(kout2[1]), 32'h00FFFFFF);
    chk("d2_no_wrap", 32'(kout2[0]), 0);
`ifdef RC4_KEY_DISPATCH_PROGRESS_EN
    chk("d2_issued_count", 32'(cnt2), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
